// File: rtl/scoreboard_regfile.sv
// -----------------------------------------------------------------------------
// scoreboard_regfile
// Integer register file for the pipelined core with a per-register busy
// scoreboard. Decode reserves a destination at issue, and writeback releases it.
// Register 0 always reads as zero and is never busy.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : asynchronous active-low reset, clears data and reservations
//   rs_sel     : NRD packed read selects, port k = rs_sel[k*AW +: AW]
//   rs_data    : NRD packed read data (combinational, same-cycle write bypass)
//   rs_busy    : per read port, 1 = selected register has a pending reservation
//   rd_w       : writeback strobe
//   rd_sel     : writeback destination
//   rd_in      : writeback data
//   rsv_valid  : request to reserve rsv_sel as a pending destination
//   rsv_sel    : register to reserve
//   rsv_ready  : reservation can be accepted this cycle (independent of rsv_valid)
//   busy_cnt   : number of registers currently busy (registered)
//   idle       : no register is busy (registered)
// -----------------------------------------------------------------------------
module scoreboard_regfile #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    parameter  int NRD   = 2,
    localparam int AW    = $clog2(NREGS),
    localparam int CW    = $clog2(NREGS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rs_sel,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]      rs_busy,
    input  logic                rd_w,
    input  logic [AW-1:0]       rd_sel,
    input  logic [XLEN-1:0]     rd_in,
    input  logic                rsv_valid,
    input  logic [AW-1:0]       rsv_sel,
    output logic                rsv_ready,
    output logic [CW-1:0]       busy_cnt,
    output logic                idle
);

    logic [XLEN-1:0]  regs_r [NREGS];
    logic [NREGS-1:0] busy_r;
    logic [NREGS-1:0] busy_nxt_s;
    logic [CW-1:0]    busy_cnt_r;
    logic [CW-1:0]    cnt_nxt_s;
    logic             idle_r;
    logic             wr_en_s;
    logic             wr_hits_rsv_s;
    logic             rsv_ready_s;
    logic             rsv_set_s;
    logic             clr_s;

    // Write, reserve and counter-delta qualifiers.
    always_comb begin
        wr_en_s       = rd_w && (rd_sel != {AW{1'b0}});
        wr_hits_rsv_s = rd_w && (rd_sel == rsv_sel);
        // A writeback releasing the same register this cycle frees it for re-reservation.
        rsv_ready_s   = (rsv_sel == {AW{1'b0}}) || !busy_r[rsv_sel] || wr_hits_rsv_s;
        rsv_set_s     = rsv_valid && rsv_ready_s && (rsv_sel != {AW{1'b0}});
        // Only a write that actually clears a set bit decrements the count.
        clr_s         = wr_en_s && busy_r[rd_sel];
        // An accepted reservation always targets a bit that is clear after this
        // cycle's write, so it always increments. The same-register write-plus-reserve
        // case nets to zero through clr_s.
        cnt_nxt_s     = busy_cnt_r + CW'(rsv_set_s) - CW'(clr_s);
    end

    // Next busy vector: reservation has priority over a release of the same register.
    always_comb begin
        busy_nxt_s = busy_r;
        for (int i = 0; i < NREGS; i++) begin
            if (rsv_set_s && (rsv_sel == AW'(i))) begin
                busy_nxt_s[i] = 1'b1;
            end else if (wr_en_s && (rd_sel == AW'(i))) begin
                busy_nxt_s[i] = 1'b0;
            end else begin
                busy_nxt_s[i] = busy_r[i];
            end
        end
    end

    // Register array, scoreboard and busy counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
            busy_r     <= {NREGS{1'b0}};
            busy_cnt_r <= {CW{1'b0}};
            idle_r     <= 1'b1;
        end else begin
            if (wr_en_s) begin
                regs_r[rd_sel] <= rd_in;
            end
            busy_r     <= busy_nxt_s;
            busy_cnt_r <= cnt_nxt_s;
            idle_r     <= (cnt_nxt_s == {CW{1'b0}});
        end
    end

    genvar k;
    generate
        for (k = 0; k < NRD; k++) begin : g_rd
            logic [AW-1:0] sel_s;
            assign sel_s = rs_sel[k*AW +: AW];

            // Read port k: x0 forced to zero, then same-cycle write bypass, then array.
            always_comb begin
                if (!rst_n || (sel_s == {AW{1'b0}})) begin
                    rs_data[k*XLEN +: XLEN] = {XLEN{1'b0}};
                    rs_busy[k]              = 1'b0;
                end else if (rd_w && (rd_sel == sel_s)) begin
                    rs_data[k*XLEN +: XLEN] = rd_in;
                    rs_busy[k]              = 1'b0;
                end else begin
                    rs_data[k*XLEN +: XLEN] = regs_r[sel_s];
                    rs_busy[k]              = busy_r[sel_s];
                end
            end
        end
    endgenerate

    assign rsv_ready = rsv_ready_s;
    assign busy_cnt  = busy_cnt_r;
    assign idle      = idle_r;

endmodule

// File: tb/tb_scoreboard_regfile.sv
module tb_scoreboard_regfile;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  rs_sel = 10'd0;
    logic [63:0] rs_data;
    logic [1:0]  rs_busy;
    logic        rd_w = 1'b0;
    logic [4:0]  rd_sel = 5'd0;
    logic [31:0] rd_in = 32'd0;
    logic        rsv_valid = 1'b0;
    logic [4:0]  rsv_sel = 5'd0;
    logic        rsv_ready;
    logic [5:0]  busy_cnt;
    logic        idle;

    int checks = 0;
    int failures = 0;

    // Reference model: architectural register values and the set of reserved registers.
    logic [31:0] m_regs [32];
    bit          m_busy [32];

    scoreboard_regfile dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs_sel    (rs_sel),
        .rs_data   (rs_data),
        .rs_busy   (rs_busy),
        .rd_w      (rd_w),
        .rd_sel    (rd_sel),
        .rd_in     (rd_in),
        .rsv_valid (rsv_valid),
        .rsv_sel   (rsv_sel),
        .rsv_ready (rsv_ready),
        .busy_cnt  (busy_cnt),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += m_busy[i] ? 1 : 0;
        return n;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] s);
        if (s == 5'd0) return 32'd0;
        if (rd_w && rd_sel == s) return rd_in;
        return m_regs[s];
    endfunction

    function automatic logic model_busy(input logic [4:0] s);
        if (s == 5'd0) return 1'b0;
        if (rd_w && rd_sel == s) return 1'b0;
        return m_busy[s];
    endfunction

    function automatic logic model_ready();
        return (rsv_sel == 5'd0) || !m_busy[rsv_sel] || (rd_w && rd_sel == rsv_sel);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'd0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Compare every combinational output against the model for the current inputs.
    task automatic check_comb(input string tag);
        check_eq({tag, "_data0"}, {32'd0, rs_data[31:0]},  {32'd0, model_read(rs_sel[4:0])});
        check_eq({tag, "_data1"}, {32'd0, rs_data[63:32]}, {32'd0, model_read(rs_sel[9:5])});
        check_eq({tag, "_busy0"}, {63'd0, rs_busy[0]}, {63'd0, model_busy(rs_sel[4:0])});
        check_eq({tag, "_busy1"}, {63'd0, rs_busy[1]}, {63'd0, model_busy(rs_sel[9:5])});
        check_eq({tag, "_ready"}, {63'd0, rsv_ready}, {63'd0, model_ready()});
    endtask

    // One clock cycle: drive inputs, check combinational outputs, then apply the edge to the model.
    task automatic step(input string tag, input logic w, input logic [4:0] ws, input logic [31:0] wd,
                        input logic rv, input logic [4:0] rs, input logic [4:0] s0, input logic [4:0] s1);
        logic acc;
        @(negedge clk);
        rd_w = w; rd_sel = ws; rd_in = wd;
        rsv_valid = rv; rsv_sel = rs;
        rs_sel = {s1, s0};
        #1;
        check_comb(tag);
        acc = rv && model_ready();
        @(posedge clk);
        if (w && ws != 5'd0) begin
            m_regs[ws] = wd;
            m_busy[ws] = 1'b0;
        end
        if (acc && rs != 5'd0) m_busy[rs] = 1'b1;
        #1;
        check_eq({tag, "_cnt"},  {58'd0, busy_cnt}, 64'(model_count()));
        check_eq({tag, "_idle"}, {63'd0, idle}, {63'd0, model_count() == 0});
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rd_w = 1'b0; rsv_valid = 1'b0;
        model_clear();
        #1;
        check_eq("rst_cnt", {58'd0, busy_cnt}, 64'd0);
        check_eq("rst_idle", {63'd0, idle}, 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_clear();
        #2;
        // 1: reset state, all registers on both ports
        for (int i = 0; i < 32; i += 2) begin
            rs_sel = {5'(i + 1), 5'(i)};
            #1;
            check_comb("t1");
        end
        check_eq("t1_cnt", {58'd0, busy_cnt}, 64'd0);
        check_eq("t1_idle", {63'd0, idle}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // 2: write bypass then hold
        step("t2_byp", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd0);
        check_eq("t2_byp_const", {32'd0, rs_data[31:0]}, 64'hDEADBEEF);
        step("t2_hold", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd5);
        check_eq("t2_hold_const", {32'd0, rs_data[63:32]}, 64'hDEADBEEF);

        // 3: x0 write ignored, x0 reservation is a no-op
        step("t3", 1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 5'd0, 5'd0);
        check_eq("t3_x0", {32'd0, rs_data[31:0]}, 64'd0);
        check_eq("t3_cnt_const", {58'd0, busy_cnt}, 64'd0);

        // 4: reserve x7, observe busy, release through writeback
        step("t4_rsv", 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd0);
        step("t4_busy", 1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd7, 5'd0);
        check_eq("t4_busy_const", {63'd0, rs_busy[0]}, 64'd1);
        check_eq("t4_ready_const", {63'd0, rsv_ready}, 64'd0);
        step("t4_wr", 1'b1, 5'd7, 32'd42, 1'b0, 5'd7, 5'd7, 5'd0);
        check_eq("t4_wr_data", {32'd0, rs_data[31:0]}, 64'd42);
        check_eq("t4_wr_cnt", {58'd0, busy_cnt}, 64'd0);
        check_eq("t4_wr_idle", {63'd0, idle}, 64'd1);

        // 5: write and reserve the same busy register: reserve wins, data written
        step("t5_rsv", 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0);
        step("t5_both", 1'b1, 5'd9, 32'h55, 1'b1, 5'd9, 5'd9, 5'd0);
        step("t5_after", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0);
        check_eq("t5_data", {32'd0, rs_data[31:0]}, 64'h55);
        check_eq("t5_busy", {63'd0, rs_busy[0]}, 64'd1);
        check_eq("t5_cnt", {58'd0, busy_cnt}, 64'd1);

        // Randomized traffic against the model; writes favoured to keep reservations flowing.
        for (int n = 0; n < 400; n++) begin
            step("rnd", ($urandom_range(0, 99) < 60), 5'($urandom), $urandom,
                 ($urandom_range(0, 99) < 50), 5'($urandom), 5'($urandom), 5'($urandom));
        end

        // 6: fill the scoreboard, then reset mid-stream without a clock edge
        apply_reset();
        for (int i = 1; i < 32; i++) begin
            step("t6_fill", 1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 5'(i), 5'(32 - i));
        end
        check_eq("t6_full", {58'd0, busy_cnt}, 64'd31);
        @(negedge clk);
        rsv_valid = 1'b1; rsv_sel = 5'd3; rd_w = 1'b0;
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        check_eq("t6_rst_cnt", {58'd0, busy_cnt}, 64'd0);
        check_eq("t6_rst_idle", {63'd0, idle}, 64'd1);
        for (int i = 0; i < 32; i += 2) begin
            rs_sel = {5'(i + 1), 5'(i)};
            #1;
            check_eq("t6_rst_data", rs_data, 64'd0);
            check_eq("t6_rst_busy", {62'd0, rs_busy}, 64'd0);
        end
        check_eq("t6_rst_ready", {63'd0, rsv_ready}, 64'd1);
        rsv_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step("t6_post", 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd4, 5'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
